// File: rtl/ring_out_arb_pkg.sv
// Shared ring router definitions: flit width, header fields and
// the output-buffer state encoding.
package ring_out_arb_pkg;

  localparam int DATA_W_DEF = 64;

  // Header layout consumed by the input handler
  localparam int HDR_HOP_LSB = 0;
  localparam int HDR_HOP_W   = 4;
  localparam int HDR_DIR_BIT = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with last-grant memory.
// gnt[0] is requester A, gnt[1] is requester B.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (!reset && en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  // Reset to B so that A wins the first contention
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt[0]) begin
      last_grant <= 1'b0;
    end else if (gnt[1]) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/ring_out_arb.sv
// Ring router output channel: two-way round-robin arbiter feeding a
// one-entry output buffer, plus saturating per-requester flit counters.
module ring_out_arb
  import ring_out_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fwd_v_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              fwd_v_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              fwd_en_a,
  output logic              fwd_en_b,
  output logic              out_so,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ro,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  input  logic              clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  buf_st_e    state;
  buf_st_e    state_nx;
  logic       can_accept;
  logic       grant;
  logic [1:0] gnt;

  // A full buffer frees its slot in the same cycle it drains
  assign can_accept = (state == ST_EMPTY) ||
                      ((state == ST_FULL) && out_ro);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (can_accept),
    .req   ({fwd_v_b, fwd_v_a}),
    .gnt   (gnt)
  );

  assign fwd_en_a = gnt[0];
  assign fwd_en_b = gnt[1];
  assign grant    = gnt[0] | gnt[1];
  assign out_so   = (state == ST_FULL);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_EMPTY: begin
        if (grant) state_nx = ST_FULL;
      end
      ST_FULL: begin
        if (grant) state_nx = ST_FULL;
        else if (out_ro) state_nx = ST_EMPTY;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (gnt[0]) begin
      out_data <= data_a;
    end else if (gnt[1]) begin
      out_data <= data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (gnt[0] && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + 1'b1;
      if (gnt[1] && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_out_arb.sv
// Directed bench for ring_out_arb with a narrow counter so that
// saturation is reachable.
module tb_ring_out_arb;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fwd_v_a, fwd_v_b;
  logic [DW-1:0] data_a, data_b;
  logic          fwd_en_a, fwd_en_b;
  logic          out_so;
  logic [DW-1:0] out_data;
  logic          out_ro;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          clr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ring_out_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .fwd_v_a  (fwd_v_a),
    .data_a   (data_a),
    .fwd_v_b  (fwd_v_b),
    .data_b   (data_b),
    .fwd_en_a (fwd_en_a),
    .fwd_en_b (fwd_en_b),
    .out_so   (out_so),
    .out_data (out_data),
    .out_ro   (out_ro),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .clr_cnt  (clr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_both(input string tag);
    chk(tag, 64'(fwd_en_a & fwd_en_b), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    fwd_v_a = 1'b0; fwd_v_b = 1'b0;
    data_a = '0; data_b = '0;
    out_ro = 1'b0; clr_cnt = 1'b0;
    tick(); tick();
    chk("rst_so", 64'(out_so), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("rst_cnt_b", 64'(cnt_b), 64'd0);

    // 1: single requester
    reset = 1'b0;
    fwd_v_a = 1'b1; data_a = 64'h1; out_ro = 1'b1;
    #1;
    chk("t1_en_a", 64'(fwd_en_a), 64'd1);
    chk("t1_en_b", 64'(fwd_en_b), 64'd0);
    tick();
    fwd_v_a = 1'b0;
    #1;
    chk("t1_so", 64'(out_so), 64'd1);
    chk("t1_data", out_data, 64'h1);
    chk("t1_cnt_a", 64'(cnt_a), 64'd1);

    // restart so the contention begins from the reset grant history
    reset = 1'b1;
    tick();
    chk("rst2_so", 64'(out_so), 64'd0);
    chk("rst2_cnt_a", 64'(cnt_a), 64'd0);
    reset = 1'b0;

    // 2: contention A,B,A,B
    fwd_v_a = 1'b1; fwd_v_b = 1'b1;
    data_a = 64'hA; data_b = 64'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_en_a%0d", i), 64'(fwd_en_a), 64'((i % 2) == 0));
      chk($sformatf("t2_en_b%0d", i), 64'(fwd_en_b), 64'((i % 2) == 1));
      no_both($sformatf("t2_both%0d", i));
      tick();
      chk($sformatf("t2_data%0d", i), out_data,
          ((i % 2) == 0) ? 64'hA : 64'hB);
    end
    fwd_v_a = 1'b0; fwd_v_b = 1'b0;
    chk("t2_cnt_a", 64'(cnt_a), 64'd2);
    chk("t2_cnt_b", 64'(cnt_b), 64'd2);

    // 3: backpressure
    fwd_v_a = 1'b1; data_a = 64'hAA;
    #1;
    chk("t3_fill_en", 64'(fwd_en_a), 64'd1);
    tick();
    chk("t3_fill_data", out_data, 64'hAA);
    data_a = 64'hCC; out_ro = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t3_stall_en%0d", i), 64'(fwd_en_a), 64'd0);
      tick();
      chk($sformatf("t3_hold%0d", i), out_data, 64'hAA);
      chk($sformatf("t3_so%0d", i), 64'(out_so), 64'd1);
    end
    out_ro = 1'b1;
    #1;
    chk("t3_resume_en", 64'(fwd_en_a), 64'd1);
    tick();
    fwd_v_a = 1'b0;
    chk("t3_next", out_data, 64'hCC);
    chk("t3_cnt_a", 64'(cnt_a), 64'd4);

    // 4: drain, then ro pulses while empty
    tick();
    chk("t4_empty", 64'(out_so), 64'd0);
    out_ro = 1'b0;
    tick();
    out_ro = 1'b1;
    #1;
    chk("t4_no_en", 64'(fwd_en_a | fwd_en_b), 64'd0);
    tick();
    chk("t4_still_empty", 64'(out_so), 64'd0);
    chk("t4_data_held", out_data, 64'hCC);

    // 5: saturation and clear priority
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t5_clr", 64'(cnt_a), 64'd0);
    fwd_v_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_a = 64'(i);
      tick();
    end
    chk("t5_sat", 64'(cnt_a), 64'd15);
    chk("t5_last", out_data, 64'd16);
    clr_cnt = 1'b1;
    #1;
    chk("t5_clr_en", 64'(fwd_en_a), 64'd1);
    tick();
    clr_cnt = 1'b0;
    chk("t5_clr_pri", 64'(cnt_a), 64'd0);

    // 6: reset mid-operation
    data_a = 64'h55;
    tick();
    chk("t6_full", out_data, 64'h55);
    chk("t6_cnt_a", 64'(cnt_a), 64'd1);
    fwd_v_b = 1'b1; data_a = 64'h66; data_b = 64'h77;
    out_ro = 1'b0;
    #1;
    chk("t6_pend", 64'(fwd_en_a | fwd_en_b), 64'd0);
    reset = 1'b1; out_ro = 1'b1;
    #1;
    chk("t6_rst_gnt", 64'(fwd_en_a | fwd_en_b), 64'd0);
    tick();
    chk("t6_rst_so", 64'(out_so), 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    chk("t6_rst_cnt", 64'({cnt_a, cnt_b}), 64'd0);
    reset = 1'b0;
    #1;
    chk("t6_a_first", 64'(fwd_en_a), 64'd1);
    chk("t6_b_wait", 64'(fwd_en_b), 64'd0);
    tick();
    chk("t6_data_a", out_data, 64'h66);
    #1;
    chk("t6_b_next", 64'(fwd_en_b), 64'd1);
    no_both("t6_both");
    tick();
    chk("t6_data_b", out_data, 64'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
